// File: rtl/xge_xgmii_pkg.sv
// rtl/xge_xgmii_pkg.sv - XGMII character constants and loopback mode type
package xge_xgmii_pkg;

   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERROR = 8'hFE;

   typedef enum logic [1:0] {
      LOOP_PASS   = 2'd0,
      LOOP_INJECT = 2'd1,
      LOOP_DROP   = 2'd2,
      LOOP_RSVD   = 2'd3
   } loop_mode_t;

   function automatic logic is_char(input logic [7:0] d, input logic c, input logic [7:0] ch);
      return c && (d == ch);
   endfunction

endpackage

// File: rtl/xgmii_delay_line.sv
// rtl/xgmii_delay_line.sv - circular delay line with programmable depth
// Tracks how many non-idle words it holds so the owner knows when it is safe to retime.
module xgmii_delay_line #(
   parameter int                 WIDTH     = 72,
   parameter int                 MAX_DELAY = 16,
   parameter logic [WIDTH-1:0]   IDLE_WORD = '0,
   localparam int                DW        = $clog2(MAX_DELAY + 1),
   localparam int                PW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DW-1:0]    delay,
   input  logic [WIDTH-1:0] din,
   input  logic             din_busy,
   output logic [WIDTH-1:0] dout,
   output logic             line_empty
);

   logic [WIDTH-1:0]     mem_q [MAX_DELAY];
   logic [WIDTH-1:0]     mem_d [MAX_DELAY];
   logic [MAX_DELAY-1:0] busy_q, busy_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr;
   logic [DW-1:0]        occ_q, occ_d;
   logic                 wr_busy;
   int                   rd_i;

   always_comb begin
      // With zero delay the line is bypassed; storing idle keeps stale words from resurfacing later.
      wr_busy = (delay != '0) && din_busy;
      mem_d   = mem_q;
      busy_d  = busy_q;
      mem_d[wr_ptr_q]  = (delay == '0) ? IDLE_WORD : din;
      busy_d[wr_ptr_q] = wr_busy;
      occ_d    = occ_q + DW'(wr_busy) - DW'(busy_q[wr_ptr_q]);
      wr_ptr_d = (wr_ptr_q == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + 1'b1;
      rd_i     = int'(wr_ptr_q) - int'(delay);
      if (rd_i < 0) begin
         rd_i = rd_i + MAX_DELAY;
      end
      rd_ptr     = PW'(rd_i);
      dout       = (delay == '0) ? din : mem_q[rd_ptr];
      line_empty = (occ_q == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_DELAY; i++) begin
            mem_q[i] <= IDLE_WORD;
         end
         busy_q   <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         busy_q   <= busy_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: rtl/xgmii_loopback_chan.sv
// rtl/xgmii_loopback_chan.sv - XGMII TX-to-RX loopback with delay, frame counting and error injection/drop
module xgmii_loopback_chan
   import xge_xgmii_pkg::*;
#(
   parameter int  LANES     = 8,
   parameter int  MAX_DELAY = 16,
   localparam int DW        = $clog2(MAX_DELAY + 1),
   localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                 clk_xgmii,
   input  logic                 reset_xgmii,
   input  logic [8*LANES-1:0]   xgmii_txd,
   input  logic [LANES-1:0]     xgmii_txc,
   output logic [8*LANES-1:0]   xgmii_rxd,
   output logic [LANES-1:0]     xgmii_rxc,
   input  logic [1:0]           cfg_mode,
   input  logic [DW-1:0]        cfg_delay,
   input  logic [15:0]          cfg_err_every,
   input  logic [LW-1:0]        cfg_err_lane,
   output logic                 in_frame,
   output logic [31:0]          frame_cnt,
   output logic [15:0]          inj_cnt
);

   localparam int            WW        = 9 * LANES;
   localparam logic [WW-1:0] IDLE_WORD = {{LANES{1'b1}}, {LANES{XGMII_IDLE}}};

   logic [WW-1:0] s1_word_q, s1_word_d, out_word_q, out_word_d, line_dout;
   logic          in_frame_q, in_frame_d, inj_pend_q, inj_pend_d, drop_q, drop_d;
   logic [31:0]   frame_cnt_q, frame_cnt_d;
   logic [15:0]   inj_cnt_q, inj_cnt_d, sel_cnt_q, sel_cnt_d;
   loop_mode_t    mode_q, mode_d;
   logic [DW-1:0] delay_q, delay_d;
   logic [15:0]   every_q, every_d;
   logic [LW-1:0] lane_q, lane_d;
   logic          line_empty, cfg_load, is_sop, is_term, is_data, sel_hit, act_hit;

   // Retiming is only safe once nothing of a frame remains anywhere in the pipe.
   always_comb begin
      cfg_load = !in_frame_q && line_empty && (s1_word_q == IDLE_WORD);
      mode_d   = mode_q;
      delay_d  = delay_q;
      every_d  = every_q;
      lane_d   = lane_q;
      if (cfg_load) begin
         mode_d  = loop_mode_t'(cfg_mode);
         delay_d = (cfg_delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : cfg_delay;
         every_d = cfg_err_every;
         lane_d  = cfg_err_lane;
      end
   end

   always_comb begin
      is_sop  = is_char(xgmii_txd[7:0], xgmii_txc[0], XGMII_START);
      is_term = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (is_char(xgmii_txd[i*8 +: 8], xgmii_txc[i], XGMII_TERM)) begin
            is_term = 1'b1;
         end
      end
      is_data = (xgmii_txc == '0);
   end

   always_comb begin
      s1_word_d   = {xgmii_txc, xgmii_txd};
      in_frame_d  = in_frame_q;
      frame_cnt_d = frame_cnt_q;
      sel_cnt_d   = sel_cnt_q;
      inj_pend_d  = inj_pend_q;
      drop_d      = drop_q;
      inj_cnt_d   = inj_cnt_q;
      sel_hit     = 1'b0;
      act_hit     = 1'b0;
      if (is_sop) begin
         frame_cnt_d = frame_cnt_q + 32'd1;
         in_frame_d  = !is_term;
         if (every_d != '0) begin
            if ({1'b0, sel_cnt_q} + 17'd1 >= {1'b0, every_d}) begin
               sel_cnt_d = '0;
               sel_hit   = 1'b1;
            end else begin
               sel_cnt_d = sel_cnt_q + 16'd1;
            end
         end
         inj_pend_d = sel_hit && (mode_d == LOOP_INJECT) && !is_term;
         drop_d     = sel_hit && (mode_d == LOOP_DROP) && !is_term;
         if (sel_hit && (mode_d == LOOP_DROP)) begin
            s1_word_d = IDLE_WORD;
            act_hit   = 1'b1;
         end
      end else if (in_frame_q) begin
         if (drop_q) begin
            s1_word_d = IDLE_WORD;
         end else if (inj_pend_q && is_data) begin
            if (int'(lane_d) < LANES) begin
               s1_word_d[8*LANES + int'(lane_d)] = 1'b1;
               s1_word_d[int'(lane_d)*8 +: 8]    = XGMII_ERROR;
            end
            inj_pend_d = 1'b0;
            act_hit    = 1'b1;
         end
         if (is_term) begin
            in_frame_d = 1'b0;
            inj_pend_d = 1'b0;
            drop_d     = 1'b0;
         end
      end
      if (act_hit && (inj_cnt_q != 16'hFFFF)) begin
         inj_cnt_d = inj_cnt_q + 16'd1;
      end
   end

   xgmii_delay_line #(
      .WIDTH     (WW),
      .MAX_DELAY (MAX_DELAY),
      .IDLE_WORD (IDLE_WORD)
   ) u_delay_line (
      .clk        (clk_xgmii),
      .rst        (reset_xgmii),
      .delay      (delay_q),
      .din        (s1_word_q),
      .din_busy   (s1_word_q != IDLE_WORD),
      .dout       (line_dout),
      .line_empty (line_empty)
   );

   always_comb begin
      out_word_d = line_dout;
   end

   always_ff @(posedge clk_xgmii or posedge reset_xgmii) begin
      if (reset_xgmii) begin
         s1_word_q   <= IDLE_WORD;
         out_word_q  <= IDLE_WORD;
         in_frame_q  <= 1'b0;
         frame_cnt_q <= '0;
         inj_cnt_q   <= '0;
         sel_cnt_q   <= '0;
         inj_pend_q  <= 1'b0;
         drop_q      <= 1'b0;
         mode_q      <= LOOP_PASS;
         delay_q     <= '0;
         every_q     <= '0;
         lane_q      <= '0;
      end else begin
         s1_word_q   <= s1_word_d;
         out_word_q  <= out_word_d;
         in_frame_q  <= in_frame_d;
         frame_cnt_q <= frame_cnt_d;
         inj_cnt_q   <= inj_cnt_d;
         sel_cnt_q   <= sel_cnt_d;
         inj_pend_q  <= inj_pend_d;
         drop_q      <= drop_d;
         mode_q      <= mode_d;
         delay_q     <= delay_d;
         every_q     <= every_d;
         lane_q      <= lane_d;
      end
   end

   assign xgmii_rxd = out_word_q[8*LANES-1:0];
   assign xgmii_rxc = out_word_q[WW-1:8*LANES];
   assign in_frame  = in_frame_q;
   assign frame_cnt = frame_cnt_q;
   assign inj_cnt   = inj_cnt_q;

endmodule

// File: tb/tb_xgmii_loopback_chan.sv
// tb/tb_xgmii_loopback_chan.sv - randomized check of xgmii_loopback_chan against a frame-level model
module tb_xgmii_loopback_chan;

   localparam int          LANES     = 8;
   localparam int          MAX_DELAY = 16;
   localparam int          DW        = $clog2(MAX_DELAY + 1);
   localparam logic [71:0] IDLE_W    = {8'hFF, {8{8'h07}}};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] txd = {8{8'h07}};
   logic [7:0]  txc = 8'hFF;
   logic [63:0] rxd;
   logic [7:0]  rxc;
   logic [1:0]  cfg_mode = 2'd0;
   logic [DW-1:0] cfg_delay = '0;
   logic [15:0] cfg_err_every = 16'd0;
   logic [2:0]  cfg_err_lane = 3'd0;
   logic        in_frame;
   logic [31:0] frame_cnt;
   logic [15:0] inj_cnt;

   always #5 clk = ~clk;

   xgmii_loopback_chan #(.LANES(LANES), .MAX_DELAY(MAX_DELAY)) dut (
      .clk_xgmii     (clk),
      .reset_xgmii   (rst),
      .xgmii_txd     (txd),
      .xgmii_txc     (txc),
      .xgmii_rxd     (rxd),
      .xgmii_rxc     (rxc),
      .cfg_mode      (cfg_mode),
      .cfg_delay     (cfg_delay),
      .cfg_err_every (cfg_err_every),
      .cfg_err_lane  (cfg_err_lane),
      .in_frame      (in_frame),
      .frame_cnt     (frame_cnt),
      .inj_cnt       (inj_cnt)
   );

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;

   int m_frames, m_inj, m_since, idle_run;
   bit m_in_frame, m_pend, m_drop;
   int a_mode, a_delay, a_every, a_lane;
   logic [71:0] exp_q [int];

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_frames = 0; m_inj = 0; m_since = 0;
      m_in_frame = 0; m_pend = 0; m_drop = 0;
      a_mode = 0; a_delay = 0; a_every = 0; a_lane = 0;
      idle_run = 1000;
   endtask

   // Frame-level reference: config is adopted only after a long quiet gap outside a frame.
   task automatic model(input logic [71:0] w);
      logic [71:0] o;
      bit sop, term, data, sel, bump;
      o = w;
      bump = 0;
      if (!m_in_frame && idle_run >= 20) begin
         a_mode  = int'(cfg_mode);
         a_delay = (int'(cfg_delay) > MAX_DELAY) ? MAX_DELAY : int'(cfg_delay);
         a_every = int'(cfg_err_every);
         a_lane  = int'(cfg_err_lane);
      end
      sop  = w[64] && (w[7:0] == 8'hFB);
      term = 0;
      for (int i = 0; i < LANES; i++) begin
         if (w[64+i] && (w[i*8 +: 8] == 8'hFD)) term = 1;
      end
      data = (w[71:64] == 8'h00);
      if (sop) begin
         m_frames++;
         m_in_frame = !term;
         sel = 0;
         if (a_every != 0) begin
            m_since++;
            if (m_since >= a_every) begin
               sel = 1;
               m_since = 0;
            end
         end
         m_pend = sel && (a_mode == 1) && !term;
         m_drop = sel && (a_mode == 2) && !term;
         if (sel && a_mode == 2) begin
            o = IDLE_W;
            bump = 1;
         end
      end else if (m_in_frame) begin
         if (m_drop) begin
            o = IDLE_W;
         end else if (m_pend && data) begin
            o[a_lane*8 +: 8] = 8'hFE;
            o[64 + a_lane] = 1'b1;
            m_pend = 0;
            bump = 1;
         end
         if (term) begin
            m_in_frame = 0;
            m_pend = 0;
            m_drop = 0;
         end
      end
      if (bump && m_inj < 65535) m_inj++;
      if (w == IDLE_W) idle_run++;
      else idle_run = 0;
      if (o != IDLE_W) exp_q[cyc + 2 + a_delay] = o;
   endtask

   task automatic step(input logic [71:0] w, input bit r = 0);
      logic [71:0] e;
      @(negedge clk);
      e = IDLE_W;
      if (exp_q.exists(cyc)) begin
         e = exp_q[cyc];
         exp_q.delete(cyc);
      end
      chk("rx", {rxc, rxd}, e);
      if (r) begin
         rst = 1'b1;
         model_reset();
      end else begin
         rst = 1'b0;
      end
      {txc, txd} = w;
      if (!r) model(w);
      cyc++;
   endtask

   task automatic idles(input int n);
      repeat (n) step(IDLE_W);
   endtask

   task automatic chk_cnt(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "_frame_cnt"}, 72'(frame_cnt), 72'(m_frames));
      chk({tag, "_inj_cnt"}, 72'(inj_cnt), 72'(m_inj));
      chk({tag, "_in_frame"}, 72'(in_frame), 72'(m_in_frame));
   endtask

   function automatic logic [71:0] data_word();
      return {8'h00, $urandom, $urandom};
   endfunction

   function automatic logic [71:0] term_word(input int tl);
      logic [71:0] w;
      w = {8'h00, $urandom, $urandom};
      for (int i = 0; i < LANES; i++) begin
         if (i == tl) begin
            w[i*8 +: 8] = 8'hFD;
            w[64+i] = 1'b1;
         end else if (i > tl) begin
            w[i*8 +: 8] = 8'h07;
            w[64+i] = 1'b1;
         end
      end
      return w;
   endfunction

   task automatic send_frame(input int nd, input int tl, input bit has_term,
                             input int chg_at = -1, input logic [DW-1:0] chg_delay = '0);
      logic [71:0] sop_w;
      sop_w = {8'h01, 8'hD5, {6{8'h55}}, 8'hFB};
      step(sop_w);
      for (int i = 0; i < nd; i++) begin
         if (i == chg_at) cfg_delay = chg_delay;
         step(data_word());
      end
      if (has_term) step(term_word(tl));
   endtask

   task automatic one_word_frame();
      step({8'hF1, 8'h07, 8'h07, 8'h07, 8'hFD, 8'h12, 8'h34, 8'h56, 8'hFB});
   endtask

   initial begin
      logic [71:0] ord_w;
      int kind;
      ord_w = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h9C};
      model_reset();

      repeat (5) step(IDLE_W, 1);
      step(IDLE_W);
      chk_cnt("reset");
      chk("reset_rx", {rxc, rxd}, {8'hFF, 64'h0707070707070707});
      chk("reset_frames", 72'(frame_cnt), 72'd0);
      chk("reset_inj", 72'(inj_cnt), 72'd0);

      // pass-through, zero delay
      idles(24);
      send_frame(7, 0, 1);
      idles(8);
      chk_cnt("pass");
      chk("pass_frames", 72'(frame_cnt), 72'd1);
      chk("pass_inj", 72'(inj_cnt), 72'd0);

      // delay change requested mid-frame only applies to the next frame
      cfg_delay = 5'd5;
      idles(24);
      send_frame(7, 2, 1, 3, 5'd3);
      idles(24);
      send_frame(5, 5, 1);
      idles(30);
      chk_cnt("delay");

      // inject every 2nd frame on lane 3
      cfg_mode = 2'd1; cfg_err_every = 16'd2; cfg_err_lane = 3'd3;
      idles(24);
      repeat (4) begin
         send_frame(3, 4, 1);
         idles(3);
      end
      idles(20);
      chk_cnt("inject");
      chk("inject_inj", 72'(inj_cnt), 72'd2);
      chk("inject_frames", 72'(frame_cnt), 72'd7);

      // drop every frame, including a single-word frame
      cfg_mode = 2'd2; cfg_err_every = 16'd1;
      idles(24);
      send_frame(2, 3, 1);
      idles(2);
      send_frame(4, 1, 1);
      idles(2);
      one_word_frame();
      idles(24);
      chk_cnt("drop");
      chk("drop_inj", 72'(inj_cnt), 72'd5);
      chk("drop_frames", 72'(frame_cnt), 72'd10);

      // reset in the middle of a delayed frame
      cfg_mode = 2'd0; cfg_err_every = 16'd0; cfg_delay = 5'd4;
      idles(24);
      step({8'h01, 8'hD5, {6{8'h55}}, 8'hFB});
      step(data_word());
      step(data_word());
      step(data_word(), 1);
      #1;
      chk("reset_async_rx", {rxc, rxd}, IDLE_W);
      step(data_word(), 1);
      step(data_word(), 1);
      idles(30);
      chk_cnt("midreset");
      chk("midreset_frames", 72'(frame_cnt), 72'd0);

      // randomized rounds
      for (int r = 0; r < 10; r++) begin
         cfg_mode      = 2'($urandom_range(0, 3));
         cfg_delay     = DW'($urandom_range(0, 31));
         cfg_err_every = 16'($urandom_range(0, 3));
         cfg_err_lane  = 3'($urandom_range(0, 7));
         idles(24);
         for (int f = 0; f < 6; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) one_word_frame();
            else if (kind == 1) send_frame($urandom_range(0, 4), 0, 0);
            else send_frame($urandom_range(0, 6), $urandom_range(0, 7), 1);
            if ($urandom_range(0, 3) == 0) step(ord_w);
            idles($urandom_range(0, 3));
         end
         idles(4);
         chk_cnt("random");
      end
      idles(40);
      chk_cnt("final");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
